// File: rtl/p88_loader.sv
// P88 loader: parses the 4-byte P88 header from the hps_io download stream and
// writes the payload into Konix system RAM through a small FIFO and a req/ack port.
module p88_loader #(
    parameter int INDEX      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 20
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [15:0]       ioctl_index,
    input  logic              ioctl_wr,
    input  logic [26:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              hold_reset,
    output logic              load_done,
    output logic              load_error
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HEADER = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        state;
    logic              dl_q;
    logic [1:0]        hdr_idx;
    logic [23:0]       hdr_acc;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] offset;
    logic              ovf;

    logic [ADDR_W+7:0] fifo_mem [FIFO_DEPTH];
    logic [ADDR_W+7:0] head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              req_q;

    logic              index_ok;
    logic              accepted;
    logic              dl_rise;
    logic              dl_fall;
    logic              hdr_byte;
    logic              pay_byte;
    logic [1:0]        hdr_pos;
    logic [ADDR_W:0]   addr_sum;
    logic              carry;
    logic              full;
    logic              push;
    logic              pop;
    logic              push_drop;
    logic              unused_bits;

    assign index_ok = (ioctl_index[5:0] == 6'(INDEX));
    assign accepted = ioctl_wr & ioctl_download & index_ok;
    assign dl_rise  = ioctl_download & ~dl_q & index_ok;
    assign dl_fall  = ~ioctl_download & dl_q;

    // File offset 0 always restarts the header, whatever the internal position says.
    assign hdr_byte = accepted & ((state == S_HEADER)
                                | (state == S_DATA && ioctl_addr == '0)
                                | (state == S_IDLE && dl_rise));
    assign pay_byte = accepted & (state == S_DATA) & (ioctl_addr != '0);
    assign hdr_pos  = (ioctl_addr == '0) ? 2'd0 : hdr_idx;

    assign addr_sum  = {1'b0, base} + {1'b0, offset};
    assign carry     = addr_sum[ADDR_W] | ovf;
    assign pop       = req_q & mem_ack;
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign push      = pay_byte & ~carry & (~full | pop);
    assign push_drop = pay_byte & (carry | (full & ~pop));

    assign unused_bits = ^{ioctl_index[15:6], hdr_acc};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            dl_q       <= 1'b0;
            hdr_idx    <= 2'd0;
            hdr_acc    <= '0;
            base       <= '0;
            offset     <= '0;
            ovf        <= 1'b0;
            load_error <= 1'b0;
        end else begin
            dl_q <= ioctl_download;

            if (push_drop)
                load_error <= 1'b1;

            if (pay_byte) begin
                offset <= offset + ADDR_W'(1);
                if (addr_sum[ADDR_W] || (&offset))
                    ovf <= 1'b1;
            end

            if (hdr_byte) begin
                hdr_idx <= hdr_pos + 2'd1;
                case (hdr_pos)
                    2'd0: hdr_acc[7:0]   <= ioctl_dout;
                    2'd1: hdr_acc[15:8]  <= ioctl_dout;
                    2'd2: hdr_acc[23:16] <= ioctl_dout;
                    default: begin
                        base   <= hdr_acc[ADDR_W-1:0];
                        offset <= '0;
                        ovf    <= 1'b0;
                    end
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (dl_rise) begin
                        state      <= S_HEADER;
                        load_error <= 1'b0;
                    end
                end
                S_HEADER: begin
                    if (dl_fall) begin
                        state      <= S_DRAIN;
                        load_error <= 1'b1;
                    end else if (hdr_byte && hdr_pos == 2'd3) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (dl_fall)
                        state <= S_DRAIN;
                    else if (hdr_byte)
                        state <= S_HEADER;
                end
                S_DRAIN: begin
                    if (count == '0 && !req_q)
                        state <= S_DONE;
                end
                default: begin
                    state   <= S_IDLE;
                    hdr_idx <= 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            req_q  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Dropping req for a cycle after each ack keeps the head entry stable while req=1.
            req_q <= req_q ? ~mem_ack : (count != '0);
        end
    end

    // NOTE: the FIFO storage has no reset; only pointers and count define validity,
    // and the outputs are masked whenever no request is pending.
    always_ff @(posedge clk_sys) begin
        if (push)
            fifo_mem[wr_ptr] <= {addr_sum[ADDR_W-1:0], ioctl_dout};
    end

    assign head       = fifo_mem[rd_ptr];
    assign mem_req    = req_q;
    assign mem_addr   = req_q ? head[ADDR_W+7:8] : '0;
    assign mem_wdata  = req_q ? head[7:0] : '0;
    assign ioctl_wait = (count >= CNT_W'(FIFO_DEPTH - 1));
    assign hold_reset = (state == S_HEADER) | (state == S_DATA) | (state == S_DRAIN);
    assign load_done  = (state == S_DONE) & ~load_error;

endmodule

// File: tb/tb_p88_loader.sv
// Directed bench for p88_loader: RAM writes are predicted into a scoreboard
// queue as bytes are driven and compared as the write port accepts them.
module tb_p88_loader;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [15:0] ioctl_index = 16'd0;
    logic        ioctl_wr = 1'b0;
    logic [26:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        ioctl_wait;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [19:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        hold_reset;
    logic        load_done;
    logic        load_error;

    typedef struct packed {
        logic [19:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t sb[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  done_pulses = 0;
    bit  ack_en = 1'b1;

    p88_loader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .hold_reset     (hold_reset),
        .load_done      (load_done),
        .load_error     (load_error)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write-port model: ack in the same cycle as req whenever enabled.
    always @(negedge clk_sys) begin
        wr_t e;
        if (load_done)
            done_pulses++;
        mem_ack = ack_en && mem_req;
        if (mem_ack) begin
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_write: observed addr 0x%0h data 0x%0h expected none",
                       mem_addr, mem_wdata);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", 32'(mem_wdata), 32'(e.data));
            end
        end
    end

    task automatic expect_write(input int a, input logic [7:0] d);
        wr_t e;
        if (a < 32'h100000) begin
            e.addr = a[19:0];
            e.data = d;
            sb.push_back(e);
        end
    endtask

    task automatic send_byte(input logic [26:0] a, input logic [7:0] d);
        int waited = 0;
        while (ioctl_wait && waited < 200) begin
            @(negedge clk_sys);
            waited++;
        end
        check("wait_bound", 32'(waited >= 200), 32'd0);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
    endtask

    task automatic start_dl(input logic [15:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic send_header(input logic [23:0] b);
        send_byte(27'd0, b[7:0]);
        send_byte(27'd1, b[15:8]);
        send_byte(27'd2, b[23:16]);
        send_byte(27'd3, 8'h5A);
    endtask

    task automatic finish_load();
        int n = 0;
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        while (hold_reset && n < 500) begin
            @(negedge clk_sys);
            n++;
        end
        check("drain_bound", 32'(n >= 500), 32'd0);
        repeat (3) @(negedge clk_sys);
    endtask

    initial begin
        int d0;
        logic [7:0] pay1 [3];
        pay1[0] = 8'hAA;
        pay1[1] = 8'hBB;
        pay1[2] = 8'hCC;

        repeat (3) @(negedge clk_sys);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_hold", 32'(hold_reset), 32'd0);
        check("rst_wait", 32'(ioctl_wait), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_error), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        @(negedge clk_sys);

        // 1: basic load
        d0 = done_pulses;
        start_dl(16'd4);
        check("t1_hold_hi", 32'(hold_reset), 32'd1);
        send_header(24'h001000);
        for (int i = 0; i < 3; i++) begin
            expect_write(32'h1000 + i, pay1[i]);
            send_byte(27'(4 + i), pay1[i]);
        end
        finish_load();
        check("t1_done", 32'(done_pulses - d0), 32'd1);
        check("t1_err", 32'(load_error), 32'd0);
        check("t1_hold_lo", 32'(hold_reset), 32'd0);
        check("t1_sb", 32'(sb.size()), 32'd0);

        // 2: stalled write port, backpressure at count 3
        d0 = done_pulses;
        ack_en = 1'b0;
        start_dl(16'h0004);
        send_header(24'h045670);
        for (int i = 0; i < 3; i++) begin
            expect_write(32'h45670 + i, 8'h10 + 8'(i));
            send_byte(27'(4 + i), 8'h10 + 8'(i));
            check("t2_wait_rise", 32'(ioctl_wait), 32'(i == 2));
        end
        repeat (20) @(negedge clk_sys);
        check("t2_wait_held", 32'(ioctl_wait), 32'd1);
        check("t2_req_held", 32'(mem_req), 32'd1);
        check("t2_addr_held", 32'(mem_addr), 32'h45670);
        check("t2_data_held", 32'(mem_wdata), 32'h10);
        ack_en = 1'b1;
        for (int i = 3; i < 8; i++) begin
            expect_write(32'h45670 + i, 8'h10 + 8'(i));
            send_byte(27'(4 + i), 8'h10 + 8'(i));
        end
        finish_load();
        check("t2_done", 32'(done_pulses - d0), 32'd1);
        check("t2_err", 32'(load_error), 32'd0);
        check("t2_sb", 32'(sb.size()), 32'd0);

        // 3: address overflow at top of 1MB space
        d0 = done_pulses;
        start_dl(16'd4);
        send_header(24'h0FFFFE);
        for (int i = 0; i < 4; i++) begin
            expect_write(32'hFFFFE + i, 8'hD0 + 8'(i));
            send_byte(27'(4 + i), 8'hD0 + 8'(i));
        end
        finish_load();
        check("t3_err", 32'(load_error), 32'd1);
        check("t3_done", 32'(done_pulses - d0), 32'd0);
        check("t3_sb", 32'(sb.size()), 32'd0);

        // 4: truncated header
        d0 = done_pulses;
        start_dl(16'd4);
        check("t4_err_clr", 32'(load_error), 32'd0);
        send_byte(27'd0, 8'h00);
        send_byte(27'd1, 8'h10);
        check("t4_hold_hi", 32'(hold_reset), 32'd1);
        finish_load();
        check("t4_err", 32'(load_error), 32'd1);
        check("t4_done", 32'(done_pulses - d0), 32'd0);
        check("t4_hold_lo", 32'(hold_reset), 32'd0);

        // 5: foreign index is ignored
        d0 = done_pulses;
        start_dl(16'd1);
        check("t5_hold", 32'(hold_reset), 32'd0);
        send_header(24'h002000);
        send_byte(27'd4, 8'h11);
        send_byte(27'd5, 8'h22);
        check("t5_hold2", 32'(hold_reset), 32'd0);
        check("t5_req", 32'(mem_req), 32'd0);
        finish_load();
        check("t5_done", 32'(done_pulses - d0), 32'd0);
        check("t5_err_kept", 32'(load_error), 32'd1);

        // 6: reset while a write is pending, then a clean reload
        ack_en = 1'b0;
        start_dl(16'd4);
        send_header(24'h002000);
        send_byte(27'd4, 8'h31);
        send_byte(27'd5, 8'h32);
        repeat (2) @(negedge clk_sys);
        check("t6_req_pending", 32'(mem_req), 32'd1);
        reset = 1'b1;
        sb.delete();
        @(negedge clk_sys);
        check("t6_req_rst", 32'(mem_req), 32'd0);
        check("t6_hold_rst", 32'(hold_reset), 32'd0);
        ioctl_download = 1'b0;
        ack_en = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        d0 = done_pulses;
        start_dl(16'd4);
        send_header(24'h003000);
        for (int i = 0; i < 3; i++) begin
            expect_write(32'h3000 + i, 8'h61 + 8'(i));
            send_byte(27'(4 + i), 8'h61 + 8'(i));
        end
        finish_load();
        check("t6_done", 32'(done_pulses - d0), 32'd1);
        check("t6_err", 32'(load_error), 32'd0);
        check("t6_sb", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
